// File: rtl/hazard_ctrl.sv
// hazard_ctrl: sequencing controller for a 5-stage pipeline (PC, IF_ID, ID_EX, EX_MEM, MEM_WB).
// It detects load-use hazards, taken branches resolved in MEM and data-memory wait.
// From these it drives the pipeline-register enables and flushes.
// It also keeps saturating stall/flush performance counters.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   ifid_rs, ifid_rt, ifid_uses_rt sources of the instruction in IF_ID
//   idex_memread, idex_rt          load in ID_EX and its destination
//   exmem_branch, exmem_zero       branch resolution in EX_MEM
//   mem_busy                       data memory not ready this cycle
//   pc_write, pc_sel_branch        PC load enable / branch-target select (combinational)
//   ifid_write, ifid_flush         IF_ID load enable / NOP insert (combinational)
//   idex_flush, exmem_flush        bubble insert into ID_EX / EX_MEM (combinational)
//   pipe_hold                      freeze ID_EX, EX_MEM, MEM_WB (combinational)
//   state                          RUN=0, LU_STALL=1, MEM_WAIT=2, FLUSH=3
//   stall_count, flush_count       saturating performance counters
module hazard_ctrl #(
    parameter int unsigned LU_STALL_CYCLES = 1,
    parameter int unsigned CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             ifid_uses_rt,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rt,
    input  logic             exmem_branch,
    input  logic             exmem_zero,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             pc_sel_branch,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             pipe_hold,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int unsigned LU_W = 4;
    localparam logic [LU_W-1:0]  LU_RELOAD = LU_W'(LU_STALL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2,
        FLUSH    = 2'd3
    } state_e;

    state_e            state_q, state_nxt;
    state_e            ret_q, ret_nxt;
    state_e            eff_state;
    logic [LU_W-1:0]   lu_cnt_q, lu_cnt_nxt;
    logic [CNT_W-1:0]  stall_q, flush_q;
    logic              flush_inc;
    logic              taken;
    logic              lu_hz;

    assign taken = exmem_branch & exmem_zero;
    assign lu_hz = idex_memread & (idex_rt != 5'd0) &
                   ((idex_rt == ifid_rs) | (ifid_uses_rt & (idex_rt == ifid_rt)));

    // State, loop counter, return state and performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            ret_q    <= RUN;
            lu_cnt_q <= '0;
            stall_q  <= '0;
            flush_q  <= '0;
        end else begin
            state_q  <= state_nxt;
            ret_q    <= ret_nxt;
            lu_cnt_q <= lu_cnt_nxt;
            if (!pc_write && stall_q != CNT_MAX) stall_q <= stall_q + CNT_W'(1);
            if (flush_inc && flush_q != CNT_MAX) flush_q <= flush_q + CNT_W'(1);
        end
    end

    // Next state and Mealy control outputs
    always_comb begin
        pc_write      = 1'b1;
        pc_sel_branch = 1'b0;
        ifid_write    = 1'b1;
        ifid_flush    = 1'b0;
        idex_flush    = 1'b0;
        exmem_flush   = 1'b0;
        pipe_hold     = 1'b0;
        state_nxt     = RUN;
        ret_nxt       = ret_q;
        lu_cnt_nxt    = lu_cnt_q;
        flush_inc     = 1'b0;
        // Leaving MEM_WAIT resumes as the saved state; ret_q is never FLUSH,
        // so branch suppression is automatically off on that cycle.
        eff_state     = (state_q == MEM_WAIT) ? ret_q : state_q;

        if (mem_busy) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            pipe_hold  = 1'b1;
            state_nxt  = MEM_WAIT;
            if (state_q != MEM_WAIT) ret_nxt = (state_q == FLUSH) ? RUN : state_q;
        end else if (eff_state == LU_STALL) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
            lu_cnt_nxt = lu_cnt_q - LU_W'(1);
            state_nxt  = (lu_cnt_q == LU_W'(1)) ? RUN : LU_STALL;
        end else if (taken && eff_state != FLUSH) begin
            // Branch wins over a simultaneous load-use: the dependent instruction is flushed
            pc_sel_branch = 1'b1;
            ifid_flush    = 1'b1;
            idex_flush    = 1'b1;
            exmem_flush   = 1'b1;
            flush_inc     = 1'b1;
            state_nxt     = FLUSH;
        end else if (lu_hz) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
            if (LU_STALL_CYCLES > 1) begin
                lu_cnt_nxt = LU_RELOAD;
                state_nxt  = LU_STALL;
            end
        end

        if (rst) begin
            pc_write      = 1'b0;
            pc_sel_branch = 1'b0;
            ifid_write    = 1'b0;
            ifid_flush    = 1'b1;
            idex_flush    = 1'b1;
            exmem_flush   = 1'b1;
            pipe_hold     = 1'b1;
            flush_inc     = 1'b0;
        end
    end

    assign state       = state_q;
    assign stall_count = stall_q;
    assign flush_count = flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl.
// Three instances: LU=1/CNT_W=16, LU=3/CNT_W=16, LU=1/CNT_W=2.
// The driver applies one vector per cycle to one instance and queues the expected response.
// The monitor pops the queue and checks at the falling edge.
module tb_hazard_ctrl;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses;
        logic       mr;
        logic [4:0] irt;
        logic       br;
        logic       z;
        logic       busy;
    } in_t;

    typedef struct {
        int          d;
        int          n;
        logic [6:0]  c;
        logic [1:0]  st;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    // {pc_write, pc_sel_branch, ifid_write, ifid_flush, idex_flush, exmem_flush, pipe_hold}
    localparam logic [6:0] C_RUN   = 7'b1010000;
    localparam logic [6:0] C_STALL = 7'b0000100;
    localparam logic [6:0] C_BR    = 7'b1111110;
    localparam logic [6:0] C_HOLD  = 7'b0000001;
    localparam logic [6:0] C_RST   = 7'b0001111;

    logic        clk = 1'b0;
    in_t         din [3];
    logic [6:0]  ctrl [3];
    logic [1:0]  st [3];
    logic [15:0] sc [3];
    logic [15:0] fc [3];
    logic [1:0]  sc2, fc2;
    exp_t        sb_q [$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_vec    = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.LU_STALL_CYCLES(1), .CNT_W(16)) u_d0 (
        .clk(clk), .rst(din[0].rst), .ifid_rs(din[0].rs), .ifid_rt(din[0].rt),
        .ifid_uses_rt(din[0].uses), .idex_memread(din[0].mr), .idex_rt(din[0].irt),
        .exmem_branch(din[0].br), .exmem_zero(din[0].z), .mem_busy(din[0].busy),
        .pc_write(ctrl[0][6]), .pc_sel_branch(ctrl[0][5]), .ifid_write(ctrl[0][4]),
        .ifid_flush(ctrl[0][3]), .idex_flush(ctrl[0][2]), .exmem_flush(ctrl[0][1]),
        .pipe_hold(ctrl[0][0]), .state(st[0]), .stall_count(sc[0]), .flush_count(fc[0])
    );

    hazard_ctrl #(.LU_STALL_CYCLES(3), .CNT_W(16)) u_d1 (
        .clk(clk), .rst(din[1].rst), .ifid_rs(din[1].rs), .ifid_rt(din[1].rt),
        .ifid_uses_rt(din[1].uses), .idex_memread(din[1].mr), .idex_rt(din[1].irt),
        .exmem_branch(din[1].br), .exmem_zero(din[1].z), .mem_busy(din[1].busy),
        .pc_write(ctrl[1][6]), .pc_sel_branch(ctrl[1][5]), .ifid_write(ctrl[1][4]),
        .ifid_flush(ctrl[1][3]), .idex_flush(ctrl[1][2]), .exmem_flush(ctrl[1][1]),
        .pipe_hold(ctrl[1][0]), .state(st[1]), .stall_count(sc[1]), .flush_count(fc[1])
    );

    hazard_ctrl #(.LU_STALL_CYCLES(1), .CNT_W(2)) u_d2 (
        .clk(clk), .rst(din[2].rst), .ifid_rs(din[2].rs), .ifid_rt(din[2].rt),
        .ifid_uses_rt(din[2].uses), .idex_memread(din[2].mr), .idex_rt(din[2].irt),
        .exmem_branch(din[2].br), .exmem_zero(din[2].z), .mem_busy(din[2].busy),
        .pc_write(ctrl[2][6]), .pc_sel_branch(ctrl[2][5]), .ifid_write(ctrl[2][4]),
        .ifid_flush(ctrl[2][3]), .idex_flush(ctrl[2][2]), .exmem_flush(ctrl[2][1]),
        .pipe_hold(ctrl[2][0]), .state(st[2]), .stall_count(sc2), .flush_count(fc2)
    );

    assign sc[2] = 16'(sc2);
    assign fc[2] = 16'(fc2);

    function automatic in_t mk(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                               input logic uses, input logic mr, input logic [4:0] irt,
                               input logic br, input logic z, input logic busy);
        in_t i;
        i.rst = rst; i.rs = rs; i.rt = rt; i.uses = uses; i.mr = mr;
        i.irt = irt; i.br = br; i.z = z; i.busy = busy;
        return i;
    endfunction

    // Apply one vector to instance d for one cycle and queue its expected response
    task automatic v(input int d, input in_t i, input logic [6:0] c, input int e_st,
                     input int e_sc, input int e_fc);
        exp_t e;
        @(posedge clk);
        #1;
        din[d] = i;
        e.d  = d;
        e.n  = n_vec;
        e.c  = c;
        e.st = 2'(e_st);
        e.sc = 16'(e_sc);
        e.fc = 16'(e_fc);
        sb_q.push_back(e);
        n_vec++;
    endtask

    // Monitor: compare whatever the driver has queued for this cycle
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            n_checks += 4;
            if (ctrl[e.d] !== e.c) begin
                n_fail++;
                $display("FAIL ctrl dut%0d vec%0d: got %b expected %b", e.d, e.n, ctrl[e.d], e.c);
            end
            if (st[e.d] !== e.st) begin
                n_fail++;
                $display("FAIL state dut%0d vec%0d: got %0d expected %0d", e.d, e.n, st[e.d], e.st);
            end
            if (sc[e.d] !== e.sc) begin
                n_fail++;
                $display("FAIL stall_count dut%0d vec%0d: got %0d expected %0d", e.d, e.n, sc[e.d], e.sc);
            end
            if (fc[e.d] !== e.fc) begin
                n_fail++;
                $display("FAIL flush_count dut%0d vec%0d: got %0d expected %0d", e.d, e.n, fc[e.d], e.fc);
            end
        end
    end

    initial begin
        in_t idle, rst_v, lu, tk;
        int  wait_cyc;
        idle  = mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
        rst_v = mk(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
        lu    = mk(0, 5'd5, 5'd0, 0, 1, 5'd5, 0, 0, 0);
        tk    = mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 1, 0);
        for (int k = 0; k < 3; k++) din[k] = rst_v;
        repeat (3) @(posedge clk);

        // Instance 0: LU=1
        v(0, rst_v, C_RST,   0, 0, 0);
        v(0, idle,  C_RUN,   0, 0, 0);
        v(0, lu,    C_STALL, 0, 0, 0);
        v(0, idle,  C_RUN,   0, 1, 0);
        v(0, mk(0, 5'd0, 5'd7, 0, 1, 5'd7, 0, 0, 0), C_RUN,   0, 1, 0);
        v(0, mk(0, 5'd0, 5'd7, 1, 1, 5'd7, 0, 0, 0), C_STALL, 0, 1, 0);
        v(0, mk(0, 5'd0, 5'd0, 1, 1, 5'd0, 0, 0, 0), C_RUN,   0, 2, 0);
        v(0, tk,    C_BR,    0, 2, 0);
        v(0, tk,    C_RUN,   3, 2, 1);
        v(0, mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0, 0), C_RUN, 0, 2, 1);
        v(0, tk,    C_BR,    0, 2, 1);
        v(0, mk(0, 5'd5, 5'd0, 0, 1, 5'd5, 1, 1, 0), C_STALL, 3, 2, 2);
        v(0, idle,  C_RUN,   0, 3, 2);
        v(0, mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 1, 1), C_HOLD, 0, 3, 2);
        v(0, mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1), C_HOLD, 2, 4, 2);
        v(0, tk,    C_BR,    2, 5, 2);
        v(0, idle,  C_RUN,   3, 5, 3);
        v(0, mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1), C_HOLD, 0, 5, 3);
        v(0, mk(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1), C_RST,  2, 6, 3);
        v(0, idle,  C_RUN,   0, 0, 0);
        v(0, rst_v, C_RST,   0, 0, 0);

        // Instance 1: LU=3
        v(1, rst_v, C_RST,   0, 0, 0);
        v(1, mk(0, 5'd5, 5'd0, 0, 1, 5'd5, 1, 1, 0), C_BR, 0, 0, 0);
        v(1, idle,  C_RUN,   3, 0, 1);
        v(1, lu,    C_STALL, 0, 0, 1);
        v(1, mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1), C_HOLD, 1, 1, 1);
        v(1, mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1), C_HOLD, 2, 2, 1);
        v(1, idle,  C_STALL, 2, 3, 1);
        v(1, tk,    C_STALL, 1, 4, 1);
        v(1, idle,  C_RUN,   0, 5, 1);
        v(1, lu,    C_STALL, 0, 5, 1);
        v(1, idle,  C_STALL, 1, 6, 1);
        v(1, idle,  C_STALL, 1, 7, 1);
        v(1, idle,  C_RUN,   0, 8, 1);
        v(1, tk,    C_BR,    0, 8, 1);
        v(1, mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 1, 1), C_HOLD, 3, 8, 2);
        v(1, tk,    C_BR,    2, 9, 2);
        v(1, idle,  C_RUN,   3, 9, 3);
        v(1, rst_v, C_RST,   0, 9, 3);

        // Instance 2: CNT_W=2 saturation
        v(2, rst_v, C_RST,   0, 0, 0);
        v(2, lu,    C_STALL, 0, 0, 0);
        v(2, lu,    C_STALL, 0, 1, 0);
        v(2, lu,    C_STALL, 0, 2, 0);
        v(2, lu,    C_STALL, 0, 3, 0);
        v(2, lu,    C_STALL, 0, 3, 0);
        v(2, idle,  C_RUN,   0, 3, 0);
        for (int k = 0; k < 4; k++) begin
            v(2, tk,   C_BR,  0, 3, k);
            v(2, idle, C_RUN, 3, 3, (k + 1 > 3) ? 3 : k + 1);
        end

        wait_cyc = 0;
        while (sb_q.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        if (sb_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d entries left expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
